// File: rtl/duty_ramp_controller.sv
// Soft-start/soft-stop duty slewer feeding the PWM generator.
// Optional target clamp enabled by defining DUTY_LIMIT_EN (limit = MAX_DUTY).
module duty_ramp_controller #(
    parameter int STEP     = 1,
    parameter int RAMP_DIV = 2500,
    parameter int MAX_DUTY = 230
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_duty,
    output logic       tgt_ready,
    output logic [7:0] duty,
    output logic       pwm_en,
    output logic       at_target,
    output logic       busy
);

    localparam int DATA_W = 8;
    localparam int PW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PW-1:0]   PRESC_MAX = PW'(RAMP_DIV - 1);
    localparam logic [DATA_W:0] STEP_X    = (DATA_W + 1)'(STEP);
    localparam logic [DATA_W-1:0] STEP_N  = DATA_W'(STEP);

    if (STEP < 1 || STEP > 255 || RAMP_DIV < 1 || MAX_DUTY < 0 || MAX_DUTY > 255) begin : g_param_check
        $error("duty_ramp_controller: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [DATA_W-1:0] target, target_nxt;
    logic [DATA_W-1:0] duty_nxt;
    logic              tick;
    logic              xfer;

    // Saturating slew toward a limit; one extra bit keeps the sum from wrapping.
    function automatic logic [DATA_W-1:0] ramp_up(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] lim);
        logic [DATA_W:0] sum;
        sum = {1'b0, cur} + STEP_X;
        return (sum > {1'b0, lim}) ? lim : sum[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ramp_down(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] floor_v);
        logic [DATA_W:0] thr;
        thr = {1'b0, floor_v} + STEP_X;
        return ({1'b0, cur} < thr) ? floor_v : (cur - STEP_N);
    endfunction

    function automatic logic [DATA_W-1:0] capture_tgt(input logic [DATA_W-1:0] raw);
`ifdef DUTY_LIMIT_EN
        logic [DATA_W-1:0] lim;
        lim = DATA_W'(MAX_DUTY);
        return (raw > lim) ? lim : raw;
`else
        return raw;
`endif
    endfunction

    assign tick = (state != IDLE) && (presc == PRESC_MAX);
    assign xfer = tgt_valid && tgt_ready;

    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty;
        presc_nxt  = presc;
        target_nxt = xfer ? capture_tgt(tgt_duty) : target;

        case (state)
            IDLE: begin
                duty_nxt  = '0;
                presc_nxt = '0;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (tick) begin
                    if (duty < target)      duty_nxt = ramp_up(duty, target);
                    else if (duty > target) duty_nxt = ramp_down(duty, target);
                end
                if (!en) state_nxt = (duty == '0) ? IDLE : STOP;
            end
            STOP: begin
                if (tick) duty_nxt = ramp_down(duty, '0);
                if (en)                          state_nxt = RUN;
                else if (tick && duty_nxt == '0) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                duty_nxt  = '0;
            end
        endcase

        // The divider free-runs across RUN/STOP and parks at zero in IDLE.
        if (state != IDLE) presc_nxt = tick ? '0 : presc + 1'b1;
        if (state_nxt == IDLE) presc_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            duty   <= '0;
            target <= '0;
            presc  <= '0;
        end else begin
            state  <= state_nxt;
            duty   <= duty_nxt;
            target <= target_nxt;
            presc  <= presc_nxt;
        end
    end

    assign tgt_ready = (state != STOP);
    assign pwm_en    = (state != IDLE);
    assign at_target = (state == RUN) && (duty == target);
    assign busy      = (state != IDLE) && ((duty != target) || (state == STOP));

endmodule

// File: doc/duty_ramp_controller.md
Name: duty_ramp_controller

Overview:
Soft-start/soft-stop stage sitting directly upstream of the PWM generator; drives its duty and en inputs.
Accepts a target duty through a valid/ready handshake and slews the output duty toward it by STEP once every RAMP_DIV clocks.
On run-request removal it ramps duty down to 0 before dropping the PWM enable, so the load never sees a hard step.

Parameters:
STEP, 1, duty LSBs added/subtracted per update tick (1..255)
RAMP_DIV, 2500, clocks per update tick (>=1); default equals one PWM period at 50 MHz/20 kHz
MAX_DUTY, 230, upper clamp on accepted target (used only with DUTY_LIMIT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  run request, level-sensitive
tgt_valid  in  1  target duty offered
tgt_duty  in  8  target duty 0-255
tgt_ready  out  1  target can be accepted
duty  out  8  ramped duty to PWM generator
pwm_en  out  1  enable to PWM generator
at_target  out  1  RUN and duty == captured target
busy  out  1  state != IDLE and (duty != target or state == STOP)

Behaviour:
- Reset (rst=0, async): state=IDLE, duty=0, pwm_en=0, target register=0, prescaler=0. Resulting outputs: tgt_ready=1, at_target=0, busy=0. Reset mid-ramp clears everything immediately, with no ramp-down.
- at_target, busy and tgt_ready are decoded from registered state only; no combinational path from any input.
- States: IDLE, RUN, STOP. pwm_en=1 in RUN and STOP.
- IDLE: duty=0, prescaler held at 0. en=1 -> RUN; pwm_en rises on the same edge.
- RUN:
  - Prescaler counts 0..RAMP_DIV-1 and wraps; tick = prescaler at RAMP_DIV-1.
  - On tick, if duty<target: duty<=min(duty+STEP,target). If duty>target: duty<=max(duty-STEP,target).
  - Arithmetic is 9-bit, so there is no wrap and no overshoot; 255 and 0 are hard limits.
- RUN, en=0:
  - If duty==0 -> IDLE next edge (pwm_en falls).
  - Otherwise -> STOP, prescaler keeps running (not reset).
- STOP:
  - tgt_ready=0.
  - On tick, duty<=max(duty-STEP,0).
  - A tick that leaves duty==0 -> IDLE on that same edge (pwm_en falls with duty reaching 0).
  - en=1 during STOP -> RUN next edge; the ramp resumes from the current duty toward the held target.
- Handshake:
  - tgt_ready=1 in IDLE and RUN.
  - Transfer occurs when tgt_valid && tgt_ready; the target register updates on that edge.
  - Preload in IDLE is allowed.
  - A new target does not reset the prescaler; it takes effect at the next tick.
  - A transfer coinciding with a tick: that tick uses the old target.
- RAMP_DIV=1: tick every clock in RUN/STOP.
- Prescaler width = $clog2(RAMP_DIV), minimum 1 bit.

Optional Feature:
DUTY_LIMIT_EN
- Defined: accepted tgt_duty is clamped to min(tgt_duty, MAX_DUTY) at capture, so duty never exceeds MAX_DUTY.
- Undefined: target is captured unmodified; full range 0-255.

Test Plan:
- RAMP_DIV=4, STEP=16; assert rst=0 mid-sim -> duty=0, pwm_en=0, tgt_ready=1, at_target=0, busy=0 immediately, with no clock edge needed.
- Preload target 64 in IDLE, then en=1 -> pwm_en=1 after 1 edge; duty 16,32,48,64 on successive ticks every 4 clocks; at_target=1 at 64.
- At duty 64, load target 70 -> duty 70, no overshoot. Then at 250 with STEP=16, load 255 -> duty 255, no wrap. A load coinciding with a tick -> old target used on that tick.
- At duty 64, set en=0 -> tgt_ready=0; duty 48,32,16,0; pwm_en falls with duty=0; IDLE. Repeat, but re-raise en at duty 32 -> RUN, ramps back to 64.
- en=0 while RUN with duty=0 -> IDLE next edge, no STOP visit.
- With DUTY_LIMIT_EN and MAX_DUTY=200: target 250 -> settles at 200. Without the macro: settles at 250.
